// File: rtl/fb_write_queue_if.sv
// Bus bundle for fb_write_queue: GPU pixel-write side, swap control,
// 16-bit memory write port and status.
//   master : GPU/memory-side driver (fb_*, swap_req, mem_ready out; status in)
//   slave  : the write queue itself
interface fb_write_queue_if #(
  parameter int unsigned FB_WIDTH   = 400,
  parameter int unsigned FB_HEIGHT  = 240,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned XW = $clog2(FB_WIDTH) + 1;
  localparam int unsigned YW = $clog2(FB_HEIGHT) + 1;
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  // GPU pixel-write side
  logic [XW-1:0] fb_x;
  logic [YW-1:0] fb_y;
  logic [15:0]   fb_color;
  logic          fb_write;

  // Buffer swap control
  logic          swap_req;
  logic          swap_done;
  logic          front_buffer;

  // Memory write port
  logic [31:0]   mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_write;
  logic          mem_ready;

  // Status
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          busy;

  modport master (
    output fb_x, fb_y, fb_color, fb_write, swap_req, mem_ready,
    input  swap_done, front_buffer, mem_addr, mem_wdata, mem_write,
           fifo_level, overflow, busy
  );

  modport slave (
    input  fb_x, fb_y, fb_color, fb_write, swap_req, mem_ready,
    output swap_done, front_buffer, mem_addr, mem_wdata, mem_write,
           fifo_level, overflow, busy
  );
endinterface

// File: rtl/fb_write_queue.sv
// fb_write_queue: pixel-write stage behind the GPU draw/clear engine.
// Converts (x, y) writes into linear back-buffer pixel addresses, queues
// them in a FIFO and drains the queue to a 16-bit memory write port with a
// ready handshake. Also owns double-buffer selection; a requested swap
// commits only once every queued write to the old back buffer has retired.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-low reset
//   bus    : fb_write_queue_if.slave
//            in : fb_x, fb_y, fb_color, fb_write, swap_req, mem_ready
//            out: swap_done, front_buffer, mem_addr, mem_wdata, mem_write,
//                 fifo_level, overflow, busy (all registered)
module fb_write_queue #(
  parameter int unsigned FB_WIDTH   = 400,
  parameter int unsigned FB_HEIGHT  = 240,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [31:0] FB_BASE0   = 32'h0000_0000,
  parameter logic [31:0] FB_BASE1   = FB_BASE0 + 32'(FB_WIDTH * FB_HEIGHT)
) (
  input  logic           clk,
  input  logic           reset,
  fb_write_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] color;
  } entry_t;

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } swap_state_t;

  entry_t        fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_ptr_n;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_n;
  entry_t        head_q;
  entry_t        head_n;
  entry_t        push_entry;
  logic          mem_write_q;
  logic          overflow_q;
  logic          front_q;
  logic          swap_done_q;
  logic          busy_q;
  logic          busy_n;
  logic          prev_swap_q;
  swap_state_t   state_q;
  swap_state_t   state_n;

  logic          in_bounds;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          swap_edge;
  logic          commit;

  // Push/pop decisions and the entry built from the incoming pixel
  always_comb begin
    in_bounds = (32'(bus.fb_x) < FB_WIDTH) && (32'(bus.fb_y) < FB_HEIGHT);
    full      = (level_q == DEPTH_L);
    pop       = mem_write_q && bus.mem_ready;
    // A full queue still accepts a push when the head retires in the same cycle
    push      = bus.fb_write && in_bounds && (!full || pop);
    drop      = bus.fb_write && in_bounds && full && !pop;

    // Address is resolved against the back buffer now, so later swaps never retarget it
    push_entry.addr  = (front_q ? FB_BASE0 : FB_BASE1)
                     + 32'(bus.fb_y) * 32'(FB_WIDTH)
                     + 32'(bus.fb_x);
    push_entry.color = bus.fb_color;
  end

  // Next queue state and next head; the head is registered so mem_* are flop outputs
  always_comb begin
    head_n   = '0;
    rd_ptr_n = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_n  = level_q + LW'(push) - LW'(pop);
    if (level_n == '0) begin
      head_n = '0;
    end else if (push && (wr_ptr_q == rd_ptr_n)) begin
      // The slot becoming the head is the one being written this edge
      head_n = push_entry;
    end else begin
      head_n = fifo_q[rd_ptr_n];
    end
  end

  // Swap FSM next state: commit only once the queue has fully drained
  always_comb begin
    state_n   = state_q;
    commit    = 1'b0;
    swap_edge = bus.swap_req && !prev_swap_q;
    case (state_q)
      S_IDLE: begin
        if (swap_edge) begin
          state_n = S_PENDING;
        end
      end
      S_PENDING: begin
        if ((level_q == '0) && !push) begin
          commit  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
    busy_n = (level_n != '0) || (state_n == S_PENDING);
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      head_q      <= '0;
      mem_write_q <= 1'b0;
      overflow_q  <= 1'b0;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
      busy_q      <= 1'b0;
      prev_swap_q <= 1'b0;
      state_q     <= S_IDLE;
    end else begin
      wr_ptr_q    <= push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_q    <= rd_ptr_n;
      level_q     <= level_n;
      head_q      <= head_n;
      mem_write_q <= (level_n != '0);
      overflow_q  <= overflow_q | drop;
      front_q     <= front_q ^ commit;
      swap_done_q <= commit;
      busy_q      <= busy_n;
      prev_swap_q <= bus.swap_req;
      state_q     <= state_n;
    end
  end

  // Queue storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= push_entry;
    end
  end

  assign bus.mem_addr     = head_q.addr;
  assign bus.mem_wdata    = head_q.color;
  assign bus.mem_write    = mem_write_q;
  assign bus.fifo_level   = level_q;
  assign bus.overflow     = overflow_q;
  assign bus.front_buffer = front_q;
  assign bus.swap_done    = swap_done_q;
  assign bus.busy         = busy_q;

endmodule

// File: doc/fb_write_queue.md
# fb_write_queue

Pixel-write stage downstream of the GPU draw/clear engine. It accepts one framebuffer pixel write per cycle from the GPU framebuffer interface and turns (x, y) into a linear pixel address in the current back buffer. Writes are buffered in a FIFO and drained to a 16-bit memory write port with a ready handshake. The block also owns double-buffer selection and performs a back/front swap only after all queued writes to the old back buffer have been retired.

## Interface
- FB_WIDTH, 400, framebuffer width in pixels
- FB_HEIGHT, 240, framebuffer height in pixels
- FIFO_DEPTH, 16, queue entries; power of two, ≥2
- FB_BASE0, 32'h0000_0000, pixel address of buffer 0
- FB_BASE1, FB_BASE0 + FB_WIDTH*FB_HEIGHT, pixel address of buffer 1

Ports:
- clk  in  1  clock, all logic rising-edge
- reset  in  1  asynchronous, active-low reset
- fb_x  in  $clog2(FB_WIDTH)+1  pixel x from GPU
- fb_y  in  $clog2(FB_HEIGHT)+1  pixel y from GPU
- fb_color  in  16  pixel color
- fb_write  in  1  push request for (fb_x, fb_y, fb_color)
- swap_req  in  1  rising edge requests buffer swap
- swap_done  out  1  one-cycle pulse when swap commits
- front_buffer  out  1  buffer index currently displayed; back = !front_buffer
- mem_addr  out  32  pixel address of queue head
- mem_wdata  out  16  color of queue head
- mem_write  out  1  high while queue non-empty
- mem_ready  in  1  memory accepts head this cycle
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries
- overflow  out  1  sticky: a write was dropped because the queue was full
- busy  out  1  queue non-empty or swap pending

## Operation
- Address at push: base(!front_buffer) + fb_y*FB_WIDTH + fb_x, computed in 32 bits. It is frozen into the entry, so later swaps do not retarget queued pixels.
- Push condition: fb_write && fb_x < FB_WIDTH && fb_y < FB_HEIGHT.
  - Out-of-bounds writes are silently dropped and do not set overflow.
- Pop condition: mem_write && mem_ready. The head advances at the clock edge.
- Full queue:
  - A push while full with no pop in the same cycle is dropped and sets overflow.
  - A push while full with a pop in the same cycle is accepted, and the level stays unchanged.
- Empty queue: mem_write=0 and mem_addr=mem_wdata=0. mem_ready is ignored.
- FIFO order is strict; there is no write combining.
- overflow is cleared only by reset.
- Swap FSM has two states, IDLE and PENDING:
  - swap_req edge detection registers the previous swap_req; an edge is prev=0 && swap_req=1.
  - IDLE: an edge moves the FSM to PENDING.
  - PENDING: when fifo_level==0 and no push in the same cycle, front_buffer toggles, swap_done pulses for 1 cycle, and the FSM returns to IDLE.
  - A swap edge while PENDING is ignored.
  - Pushes during PENDING are accepted and target the old back buffer. They delay the commit until drained.
- busy = (fifo_level!=0) || PENDING.

## Timing
- Reset (asynchronous, while reset=0):
  - fifo_level=0, mem_write=0, mem_addr=0, mem_wdata=0
  - overflow=0, swap_done=0, front_buffer=0, busy=0
  - FSM=IDLE, prev swap_req=0
- Push latency: a push sampled at edge N gives mem_write=1 with that entry at the head during cycle N+1, if the queue was previously empty.
- mem_addr and mem_wdata are stable while mem_write=1 and mem_ready=0.
- Throughput: 1 push and 1 pop per cycle sustained.
- Swap timing:
  - The edge is seen in cycle E and the FSM enters PENDING at E+1.
  - If the queue is empty and there is no push, the commit happens at the E+1 edge: front_buffer toggles and swap_done=1 during cycle E+2.
- fifo_level reflects the state after the last edge; it is registered.

## Test plan
- Reset, push (x=3, y=2, color=16'hF801), mem_ready=1 -> next cycle mem_write=1, mem_addr=FB_BASE1+803, mem_wdata=16'hF801. Following cycle mem_write=0, fifo_level=0.
- Push (x=400, y=0) and (x=0, y=240) -> nothing queued, overflow=0, busy=0.
- mem_ready=0, push 17 in-bounds pixels with FIFO_DEPTH=16 -> fifo_level=16, overflow=1. Raise mem_ready -> exactly pixels 1–16 emerge in order.
- Queue full, mem_ready=1 and push the same cycle -> push accepted, fifo_level stays 16, overflow unchanged.
- Queue 5 entries with mem_ready=0, pulse swap_req -> busy=1, front_buffer=0 held. Release mem_ready -> after the 5th pop, swap_done pulses once, front_buffer=1, and the next push addresses FB_BASE0.
- Assert reset low mid-drain with 8 entries and PENDING -> all outputs reach reset values immediately. After release, no swap_done occurs and mem_write=0.
